// File: rtl/decim_iq_ctrl.sv
// Two-channel (I/Q) decimator with runtime ratio, pick or integrate-and-dump modes, and sync re-alignment.
// Optional DECIM_PHASE_EN adds a phase port that selects which window index pick mode keeps.
module decim_iq_ctrl #(
  parameter int DATA_WIDTH = 22,
  parameter int R_MAX      = 16,
  localparam int RW        = $clog2(R_MAX + 1),
  localparam int GW        = $clog2(R_MAX),
  localparam int OUT_WIDTH = DATA_WIDTH + GW
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        din_valid,
  input  logic signed [DATA_WIDTH-1:0] i_in,
  input  logic signed [DATA_WIDTH-1:0] q_in,
  input  logic [RW-1:0]               ratio,
  input  logic                        mode,
  input  logic                        sync,
`ifdef DECIM_PHASE_EN
  input  logic [RW-1:0]               phase,
`endif
  output logic signed [OUT_WIDTH-1:0] i_out,
  output logic signed [OUT_WIDTH-1:0] q_out,
  output logic                        dout_valid,
  output logic                        busy
);

  localparam logic [RW-1:0] R_MAX_L = RW'(R_MAX);
  localparam logic [RW-1:0] ONE_L   = RW'(1);

  logic [RW-1:0]                cnt_q, cnt_d;
  logic [RW-1:0]                ratio_act_q, ratio_act_d;
  logic                         mode_act_q, mode_act_d;
  logic signed [OUT_WIDTH-1:0]  acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic signed [OUT_WIDTH-1:0]  i_out_q, i_out_d, q_out_q, q_out_d;
  logic                         dout_valid_q, dout_valid_d;
`ifdef DECIM_PHASE_EN
  logic [RW-1:0]                phase_act_q, phase_act_d;
  logic [RW-1:0]                ph_cur;
  logic [RW-1:0]                pick_idx;
`endif

  logic [RW-1:0]                r_eff, r_cur, idx;
  logic                         start, m_cur, last;
  logic signed [OUT_WIDTH-1:0]  i_ext, q_ext, sum_i, sum_q, pick_i, pick_q;

  always_comb begin
    cnt_d        = cnt_q;
    ratio_act_d  = ratio_act_q;
    mode_act_d   = mode_act_q;
    acc_i_d      = acc_i_q;
    acc_q_d      = acc_q_q;
    i_out_d      = i_out_q;
    q_out_d      = q_out_q;
    dout_valid_d = 1'b0;

    if (ratio == '0)          r_eff = ONE_L;
    else if (ratio > R_MAX_L) r_eff = R_MAX_L;
    else                      r_eff = ratio;

    // A sync with a valid sample opens a new window right here, so latch from this cycle.
    start = din_valid && (sync || (cnt_q == '0));
    r_cur = start ? r_eff : ratio_act_q;
    m_cur = start ? mode  : mode_act_q;
    idx   = start ? '0    : cnt_q;
    last  = (idx == (r_cur - ONE_L));

    i_ext = {{GW{i_in[DATA_WIDTH-1]}}, i_in};
    q_ext = {{GW{q_in[DATA_WIDTH-1]}}, q_in};
    sum_i = (idx == '0) ? i_ext : acc_i_q + i_ext;
    sum_q = (idx == '0) ? q_ext : acc_q_q + q_ext;

`ifdef DECIM_PHASE_EN
    phase_act_d = phase_act_q;
    ph_cur      = start ? phase : phase_act_q;
    pick_idx    = (ph_cur >= r_cur) ? (r_cur - ONE_L) : ph_cur;
    // Pick mode parks the chosen sample in the accumulator until the window closes.
    pick_i      = (idx == pick_idx) ? i_ext : acc_i_q;
    pick_q      = (idx == pick_idx) ? q_ext : acc_q_q;
`else
    pick_i      = i_ext;
    pick_q      = q_ext;
`endif

    if (sync) begin
      cnt_d   = '0;
      acc_i_d = '0;
      acc_q_d = '0;
    end

    if (din_valid) begin
      if (start) begin
        ratio_act_d = r_eff;
        mode_act_d  = mode;
`ifdef DECIM_PHASE_EN
        phase_act_d = phase;
`endif
      end
      if (m_cur) begin
        acc_i_d = sum_i;
        acc_q_d = sum_q;
      end else begin
        acc_i_d = pick_i;
        acc_q_d = pick_q;
      end
      if (last) begin
        cnt_d        = '0;
        dout_valid_d = 1'b1;
        i_out_d      = m_cur ? sum_i : pick_i;
        q_out_d      = m_cur ? sum_q : pick_q;
      end else begin
        cnt_d = idx + ONE_L;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      ratio_act_q  <= ONE_L;
      mode_act_q   <= 1'b0;
      acc_i_q      <= '0;
      acc_q_q      <= '0;
      i_out_q      <= '0;
      q_out_q      <= '0;
      dout_valid_q <= 1'b0;
`ifdef DECIM_PHASE_EN
      phase_act_q  <= '0;
`endif
    end else begin
      cnt_q        <= cnt_d;
      ratio_act_q  <= ratio_act_d;
      mode_act_q   <= mode_act_d;
      acc_i_q      <= acc_i_d;
      acc_q_q      <= acc_q_d;
      i_out_q      <= i_out_d;
      q_out_q      <= q_out_d;
      dout_valid_q <= dout_valid_d;
`ifdef DECIM_PHASE_EN
      phase_act_q  <= phase_act_d;
`endif
    end
  end

  assign i_out      = i_out_q;
  assign q_out      = q_out_q;
  assign dout_valid = dout_valid_q;
  assign busy       = (cnt_q != '0);

endmodule

// File: tb/tb_decim_iq_ctrl.sv
// Directed and random stimulus for decim_iq_ctrl with a behavioural window model feeding an output scoreboard.
module tb_decim_iq_ctrl;
  localparam int DW    = 22;
  localparam int R_MAX = 16;
  localparam int RW    = 5;
  localparam int OW    = 26;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 din_valid;
  logic signed [DW-1:0] i_in, q_in;
  logic [RW-1:0]        ratio;
  logic                 mode, sync;
`ifdef DECIM_PHASE_EN
  logic [RW-1:0]        phase;
`endif
  logic signed [OW-1:0] i_out, q_out;
  logic                 dout_valid, busy;

  always #5 clk = ~clk;

  decim_iq_ctrl #(.DATA_WIDTH(DW), .R_MAX(R_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .i_in(i_in), .q_in(q_in),
    .ratio(ratio), .mode(mode), .sync(sync),
`ifdef DECIM_PHASE_EN
    .phase(phase),
`endif
    .i_out(i_out), .q_out(q_out), .dout_valid(dout_valid), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic signed [OW-1:0] exp_i[$], exp_q[$];
  bit mon_en = 1'b0;

  int     m_cnt, m_r, m_pi, m_pick_i, m_pick_q;
  bit     m_mode;
  longint m_si, m_sq;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int clamp_r(input int r);
    if (r == 0) return 1;
    if (r > R_MAX) return R_MAX;
    return r;
  endfunction

  task automatic push_exp(input longint vi, input longint vq);
    logic signed [OW-1:0] ti, tq;
    ti = vi[OW-1:0];
    tq = vq[OW-1:0];
    exp_i.push_back(ti);
    exp_q.push_back(tq);
  endtask

  // Drive one cycle, advance the model, then check busy after the edge.
  task automatic step(input bit v, input int i, input int q, input bit s = 1'b0);
    din_valid = v;
    i_in      = DW'(i);
    q_in      = DW'(q);
    sync      = s;
    if (s) m_cnt = 0;
    if (v) begin
      if (m_cnt == 0) begin
        m_r    = clamp_r(int'(ratio));
        m_mode = mode;
        m_si   = 0;
        m_sq   = 0;
        m_pi   = m_r - 1;
`ifdef DECIM_PHASE_EN
        if (int'(phase) < m_r) m_pi = int'(phase);
`endif
      end
      m_si += i;
      m_sq += q;
      if (m_cnt == m_pi) begin
        m_pick_i = i;
        m_pick_q = q;
      end
      m_cnt++;
      if (m_cnt == m_r) begin
        if (m_mode) push_exp(m_si, m_sq);
        else        push_exp(longint'(m_pick_i), longint'(m_pick_q));
        m_cnt = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("busy", {63'd0, busy}, {63'd0, (m_cnt != 0)});
    din_valid = 1'b0;
    sync      = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n && dout_valid) begin
      if (exp_i.size() == 0) begin
        chk("spurious_dout_valid", 64'sd1, 64'sd0);
      end else begin
        logic signed [OW-1:0] ei, eq;
        ei = exp_i.pop_front();
        eq = exp_q.pop_front();
        chk("i_out", i_out, ei);
        chk("q_out", q_out, eq);
      end
    end
  end

  initial begin
    rst_n = 1'b0; din_valid = 1'b0; i_in = '0; q_in = '0;
    ratio = 5'd5; mode = 1'b0; sync = 1'b0;
`ifdef DECIM_PHASE_EN
    phase = '0;
`endif
    m_cnt = 0; m_r = 1; m_pi = 0; m_pick_i = 0; m_pick_q = 0; m_mode = 0; m_si = 0; m_sq = 0;
    #12;
    chk("rst_i_out", i_out, 0);
    chk("rst_q_out", q_out, 0);
    chk("rst_dout_valid", {63'd0, dout_valid}, 0);
    chk("rst_busy", {63'd0, busy}, 0);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // pick, ratio 5, ramp: 4, 9, 14 and -4, -9, -14
    ratio = 5'd5; mode = 1'b0;
    for (int k = 0; k < 15; k++) step(1'b1, k, -k);

    // integrate-and-dump, ratio 4, constants: 400 / -12
    ratio = 5'd4; mode = 1'b1;
    for (int k = 0; k < 8; k++) step(1'b1, 100, -3);

    // full-scale sums over 16 samples
    ratio = 5'd16;
    for (int k = 0; k < 16; k++) step(1'b1, (1 << 21) - 1, -(1 << 21));
    step(1'b0, 0, 0);
    chk("max_sum_i", i_out, 64'sd16 * ((64'sd1 << 21) - 1));
    chk("min_sum_q", q_out, -64'sd16 * (64'sd1 << 21));

    // gapped input, ratio 3 pick
    ratio = 5'd3; mode = 1'b0;
    for (int k = 0; k < 12; k++) step(k[0] == 1'b0, 1000 + k, -1000 - k);

    // ratio changed mid-window takes effect only at the next window
    ratio = 5'd5;
    for (int k = 0; k < 2; k++) step(1'b1, 50 + k, k);
    ratio = 5'd2;
    for (int k = 2; k < 9; k++) step(1'b1, 50 + k, k);

    // ratio 0 acts as 1 in both modes; 31 clamps to 16
    ratio = 5'd0;
    for (int k = 0; k < 3; k++) step(1'b1, -7 * k, 3 * k);
    mode = 1'b1;
    for (int k = 0; k < 3; k++) step(1'b1, 11 + k, -11 - k);
    ratio = 5'd31;
    for (int k = 0; k < 32; k++) step(1'b1, k * 3, -k);

    // sync at the 3rd sample of a ratio 4 sum window; also a lone sync
    ratio = 5'd4; mode = 1'b1;
    step(1'b1, 10, 1);
    step(1'b1, 20, 2);
    step(1'b1, 30, 3, 1'b1);
    step(1'b1, 40, 4);
    step(1'b1, 50, 5);
    step(1'b1, 60, 6);
    step(1'b0, 0, 0);
    chk("sync_sum_i", i_out, 180);
    chk("sync_sum_q", q_out, 18);
    step(1'b1, 1, 1);
    step(1'b0, 0, 0, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b1, 5, 7);

    // sync coinciding with the last sample discards that window
    ratio = 5'd3; mode = 1'b0;
    step(1'b1, 1, 1);
    step(1'b1, 2, 2);
    step(1'b1, 3, 3, 1'b1);
    step(1'b1, 4, 4);
    step(1'b1, 5, 5);

    // random traffic
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 7) == 0) ratio = RW'($urandom_range(0, 20));
      if ($urandom_range(0, 7) == 0) mode = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 3) != 0),
           int'($urandom_range(0, (1 << 22) - 1)) - (1 << 21),
           int'($urandom_range(0, (1 << 22) - 1)) - (1 << 21),
           $urandom_range(0, 19) == 0);
    end

    // async reset mid-window after outputs are nonzero
    ratio = 5'd2; mode = 1'b0;
    step(1'b1, 9, -9);
    step(1'b1, 77, -77);
    ratio = 5'd4;
    step(1'b1, 1, 1);
    step(1'b1, 2, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_i_out", i_out, 0);
    chk("arst_q_out", q_out, 0);
    chk("arst_dout_valid", {63'd0, dout_valid}, 0);
    chk("arst_busy", {63'd0, busy}, 0);
    chk("arst_pending", exp_i.size(), 0);
    m_cnt = 0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) step(1'b1, 200 + k, k);

`ifdef DECIM_PHASE_EN
    ratio = 5'd5; mode = 1'b0; phase = 5'd1;
    for (int k = 0; k < 15; k++) step(1'b1, k, -k);
    phase = 5'd9;
    for (int k = 0; k < 10; k++) step(1'b1, k, -k);
    mode = 1'b1; phase = 5'd2;
    for (int k = 0; k < 10; k++) step(1'b1, k, 2 * k);
`endif

    for (int k = 0; k < 4; k++) step(1'b0, 0, 0);
    chk("scoreboard_drained", exp_i.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
